cmp_operand_sequencer: RTL and testbench

- Sequential front end that drives the 4-bit comparator/max unit: X, Y and the 2-bit result select.
- Collects operands from slide switches, one push-button press per operand, then presents a stable, qualified operand set to the comparator.
- Sits between the board switches/keys and the comparator's X/Y/select inputs.
- Performs no comparison itself.

---
 rtl/cmp_operand_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_cmp_operand_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/cmp_operand_sequencer.sv
// Key-stepped operand entry (X, Y, select) for the 4-bit comparator/max unit.
// Optional macro AUTO_SWEEP_EN adds a SWEEP state that counts {x,y} up from READY.
module cmp_operand_sequencer #(
   parameter int WIDTH     = 4,
   parameter int SWEEP_DIV = 50000000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw,
   input  logic             key_n,
   input  logic             sweep_req,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic [1:0]       sel,
   output logic             valid,
   output logic [1:0]       stage
);

`ifdef AUTO_SWEEP_EN
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GOT_X = 3'd1,
      S_GOT_Y = 3'd2,
      S_READY = 3'd3,
      S_SWEEP = 3'd4
   } state_t;

   localparam int            CW       = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
   localparam int            XYW      = 2 * WIDTH;
   localparam logic [CW-1:0] CNT_LAST = CW'(SWEEP_DIV - 1);
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GOT_X = 2'd1,
      S_GOT_Y = 2'd2,
      S_READY = 2'd3
   } state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [1:0]       sel_q, sel_d;
   logic             valid_q, valid_d;
   logic [1:0]       stage_q, stage_d;

   logic             k1_q, k2_q, kp_q;
   logic             press_s;

   // Key synchronizer and edge register; all idle at released (1).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         k1_q <= 1'b1;
         k2_q <= 1'b1;
         kp_q <= 1'b1;
      end else begin
         k1_q <= key_n;
         k2_q <= k1_q;
         kp_q <= k2_q;
      end
   end

   assign press_s = kp_q & ~k2_q;

`ifdef AUTO_SWEEP_EN
   logic            s1_q, s2_q, sp_q;
   logic            sweep_rise_s;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XYW-1:0]  xy_inc_s;

   // Sweep request synchronizer and rising-edge register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         sp_q <= 1'b0;
      end else begin
         s1_q <= sweep_req;
         s2_q <= s1_q;
         sp_q <= s2_q;
      end
   end

   assign sweep_rise_s = s2_q & ~sp_q;
   assign xy_inc_s     = {x_q, y_q} + XYW'(1'b1);
`else
   logic unused_sweep_req_s;
   assign unused_sweep_req_s = sweep_req;
`endif

   // Next-state and operand capture; sw is only looked at on a press edge.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      sel_d   = sel_q;
`ifdef AUTO_SWEEP_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (press_s) begin
               x_d     = sw;
               state_d = S_GOT_X;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GOT_X: begin
            if (press_s) begin
               y_d     = sw;
               state_d = S_GOT_Y;
            end else begin
               state_d = S_GOT_X;
            end
         end
         S_GOT_Y: begin
            if (press_s) begin
               sel_d   = sw[1:0];
               state_d = S_READY;
            end else begin
               state_d = S_GOT_Y;
            end
         end
         S_READY: begin
            if (press_s) begin
               x_d     = sw;
               state_d = S_GOT_X;
            end
`ifdef AUTO_SWEEP_EN
            else if (sweep_rise_s) begin
               cnt_d   = {CW{1'b0}};
               state_d = S_SWEEP;
            end
`endif
            else begin
               state_d = S_READY;
            end
         end
`ifdef AUTO_SWEEP_EN
         // A press beats a coincident terminal count: abort without stepping.
         S_SWEEP: begin
            if (press_s) begin
               state_d = S_READY;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d      = {CW{1'b0}};
               {x_d, y_d} = xy_inc_s;
               if (&{x_q, y_q}) begin
                  state_d = S_READY;
               end else begin
                  state_d = S_SWEEP;
               end
            end else begin
               cnt_d   = cnt_q + CW'(1'b1);
               state_d = S_SWEEP;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Stage and valid are decoded from the next state so they register with it.
   always_comb begin
      valid_d = 1'b0;
      stage_d = 2'd0;
      case (state_d)
         S_IDLE:  stage_d = 2'd0;
         S_GOT_X: stage_d = 2'd1;
         S_GOT_Y: stage_d = 2'd2;
         S_READY: begin
            stage_d = 2'd3;
            valid_d = 1'b1;
         end
`ifdef AUTO_SWEEP_EN
         S_SWEEP: begin
            stage_d = 2'd3;
            valid_d = 1'b1;
         end
`endif
         default: begin
            stage_d = 2'd0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         x_q     <= {WIDTH{1'b0}};
         y_q     <= {WIDTH{1'b0}};
         sel_q   <= 2'd0;
         valid_q <= 1'b0;
         stage_q <= 2'd0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         stage_q <= stage_d;
      end
   end

`ifdef AUTO_SWEEP_EN
   // Sweep divider.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign x     = x_q;
   assign y     = y_q;
   assign sel   = sel_q;
   assign valid = valid_q;
   assign stage = stage_q;

endmodule

// File: tb/tb_cmp_operand_sequencer.sv
// Scoreboard bench for cmp_operand_sequencer: stimulus queues expected output sets
// with the cycle they must appear in; a monitor pops one entry per observed change.
module tb_cmp_operand_sequencer;

   logic       clk;
   logic       reset_n;
   logic [3:0] sw;
   logic       key_n;
   logic       sweep_req;
   logic [3:0] x, y;
   logic [1:0] sel, stage;
   logic       valid;

   cmp_operand_sequencer #(.WIDTH(4), .SWEEP_DIV(2)) dut (
      .clk(clk), .reset_n(reset_n), .sw(sw), .key_n(key_n), .sweep_req(sweep_req),
      .x(x), .y(y), .sel(sel), .valid(valid), .stage(stage)
   );

   typedef struct {
      logic [3:0] x;
      logic [3:0] y;
      logic [1:0] sel;
      logic       v;
      logic [1:0] st;
      int         cyc;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   bit   mon_en = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void push(logic [3:0] ex, logic [3:0] ey, logic [1:0] es,
                                logic ev, logic [1:0] est, int ecyc);
      exp_t e;
      e.x = ex; e.y = ey; e.sel = es; e.v = ev; e.st = est; e.cyc = ecyc;
      sbq.push_back(e);
   endfunction

   // Monitor: any change of the output tuple must match the next queued entry.
   initial begin
      logic [12:0] prev, now;
      exp_t        e;
      wait (mon_en);
      prev = {x, y, sel, valid, stage};
      forever begin
         @(negedge clk or negedge reset_n);
         #1;
         now = {x, y, sel, valid, stage};
         if (now !== prev) begin
            if (sbq.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_change: got x=%0h y=%0h sel=%0d valid=%0b stage=%0d, expected no change (cycle %0d)",
                        x, y, sel, valid, stage, cyc);
            end else begin
               e = sbq.pop_front();
               check("x",     int'(x),     int'(e.x));
               check("y",     int'(y),     int'(e.y));
               check("sel",   int'(sel),   int'(e.sel));
               check("valid", int'(valid), int'(e.v));
               check("stage", int'(stage), int'(e.st));
               check("latency_cycle", cyc, e.cyc);
            end
            prev = now;
         end
      end
   end

   // Press with sw=v held stable; the update lands 3 edges after first sampling low.
   task automatic press(input logic [3:0] v, input int hold, input bit chg,
                        input logic [3:0] ex, input logic [3:0] ey, input logic [1:0] es,
                        input logic ev, input logic [1:0] est);
      @(negedge clk);
      sw    = v;
      key_n = 1'b0;
      if (chg) push(ex, ey, es, ev, est, cyc + 3);
      repeat (hold) @(negedge clk);
      key_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      reset_n   = 1'b0;
      sw        = 4'h0;
      key_n     = 1'b1;
      sweep_req = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_x",     int'(x),     0);
      check("rst_y",     int'(y),     0);
      check("rst_sel",   int'(sel),   0);
      check("rst_valid", int'(valid), 0);
      check("rst_stage", int'(stage), 0);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // Held key: one advance only.
      press(4'h5, 1000, 1'b1, 4'h5, 4'h0, 2'd0, 1'b0, 2'd1);

      // Switch isolation in GOT_X.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         sw = 4'($urandom_range(0, 15));
      end
      repeat (3) @(negedge clk);

      // Reach GOT_Y, then reset asynchronously between clock edges.
      press(4'h3, 4, 1'b1, 4'h5, 4'h3, 2'd0, 1'b0, 2'd2);
      @(negedge clk);
      #3;
      push(4'h0, 4'h0, 2'd0, 1'b0, 2'd0, cyc);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Entry sequence.
      press(4'h9, 4, 1'b1, 4'h9, 4'h0, 2'd0, 1'b0, 2'd1);
      press(4'h3, 4, 1'b1, 4'h9, 4'h3, 2'd0, 1'b0, 2'd2);
      press(4'h2, 4, 1'b1, 4'h9, 4'h3, 2'd2, 1'b1, 2'd3);
      repeat (10) @(negedge clk);

      // Restart from READY.
      press(4'hF, 4, 1'b1, 4'hF, 4'h3, 2'd2, 1'b0, 2'd1);
      press(4'hE, 4, 1'b1, 4'hF, 4'hE, 2'd2, 1'b0, 2'd2);
      press(4'h1, 4, 1'b1, 4'hF, 4'hE, 2'd1, 1'b1, 2'd3);

`ifdef AUTO_SWEEP_EN
      // Sweep F,E -> F,F -> 0,0 then back to READY.
      @(negedge clk);
      sweep_req = 1'b1;
      push(4'hF, 4'hF, 2'd1, 1'b1, 2'd3, cyc + 5);
      push(4'h0, 4'h0, 2'd1, 1'b1, 2'd3, cyc + 7);
      repeat (4) @(negedge clk);
      sweep_req = 1'b0;
      repeat (12) @(negedge clk);

      // Second sweep aborted by a press coinciding with a terminal count.
      sweep_req = 1'b1;
      push(4'h0, 4'h1, 2'd1, 1'b1, 2'd3, cyc + 5);
      push(4'h0, 4'h2, 2'd1, 1'b1, 2'd3, cyc + 7);
      repeat (6) @(negedge clk);
      sweep_req = 1'b0;
      sw        = 4'h0;
      key_n     = 1'b0;
      repeat (4) @(negedge clk);
      key_n = 1'b1;
      repeat (20) @(negedge clk);
      press(4'h7, 4, 1'b1, 4'h7, 4'h2, 2'd1, 1'b0, 2'd1);
`else
      // Without the option sweep_req has no effect.
      @(negedge clk);
      sweep_req = 1'b1;
      repeat (10) @(negedge clk);
      sweep_req = 1'b0;
      repeat (5) @(negedge clk);
      press(4'h7, 4, 1'b1, 4'h7, 4'hE, 2'd1, 1'b0, 2'd1);
`endif

      repeat (10) @(negedge clk);
      check("scoreboard_drained", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
